// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot state monitor and its index decoder.
package onehot_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_ERR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Rotate the low w bits of v left by one; bit w-1 wraps into bit 0.
  function automatic logic [31:0] rotl1(input logic [31:0] v, input int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// One-hot to binary decoder; idx_o is only meaningful while legal_o is high.
module onehot_decode
  import onehot_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot_i,
  output logic             legal_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    idx_o   = '0;
    legal_o = ($countones(onehot_i) == 1);
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot_i[i]) begin
        idx_o = idx_o | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/onehot_state_monitor.sv
// Integrity monitor for a one-hot ring counter: tracks legal holds/steps,
// flags faults once per event and reports the binary index of the state.
module onehot_state_monitor
  import onehot_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int ERR_W = DEF_ERR_W,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] state_in,
  input  logic             clear_err,
  output logic [IDX_W-1:0] bin_out,
  output logic             valid,
  output logic             fault,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [IDX_W-1:0] bin_q, bin_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic             legal;
  logic [IDX_W-1:0] idx;
  logic             is_hold;
  logic             is_step;
  logic             err_event;
  logic [ERR_W-1:0] err_base;

  onehot_decode #(.WIDTH(WIDTH)) u_decode (
    .onehot_i (state_in),
    .legal_o  (legal),
    .idx_o    (idx)
  );

  assign is_hold = (state_in == prev_q);
  assign is_step = (rotl1(32'(prev_q), WIDTH) == 32'(state_in));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
      bin_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    bin_d     = bin_q;
    err_event = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_FAULT: begin
        if (legal) begin
          state_d = ST_TRACK;
          prev_d  = state_in;
          bin_d   = idx;
        end
      end
      ST_TRACK: begin
        if (legal && (is_step || is_hold)) begin
          prev_d = state_in;
          bin_d  = idx;
        end else begin
          state_d   = ST_FAULT;
          err_event = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear takes effect first so a coincident event leaves the count at one.
  always_comb begin
    err_base = clear_err ? '0 : err_q;
    err_d    = err_base;
    if (err_event && (err_base != ERR_MAX)) begin
      err_d = err_base + ERR_W'(1);
    end
  end

  always_comb begin
    bin_out   = bin_q;
    err_count = err_q;
    valid     = (state_q == ST_TRACK);
    fault     = (state_q == ST_FAULT);
  end

endmodule

// File: doc/onehot_state_monitor.md
Name: onehot_state_monitor

Overview:
Downstream consumer of the 3-bit one-hot up counter; sits between the counter's state outputs and the display/ledbar logic.
Samples the one-hot state every clock and checks it is exactly-one-hot and advances legally (Q0->Q1->Q2->Q0, or holds).
Outputs a registered binary index, a valid flag, a fault flag and a saturating error-event counter.
Used to confirm counter integrity after preset/reset and to feed binary-coded displays.

Parameters:
WIDTH, 3, number of one-hot state bits (bit i = counter state Qi).
ERR_W, 4, width of the saturating error counter.
IDX_W, clog2(WIDTH) (2 for WIDTH=3), width of the binary index; derived, not overridden.

Ports:
clock  input  1  rising-edge clock, shared with the counter.
reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
state_in  input  WIDTH  counter state {Q2cur,Q1cur,Q0cur}, bit 0 = Q0cur.
clear_err  input  1  synchronous clear of err_count.
bin_out  output  IDX_W  index of the set bit in the last legal sample.
valid  output  1  high while in TRACK; bin_out is meaningful.
fault  output  1  high while in FAULT.
err_count  output  ERR_W  number of error events since reset/clear, saturating.

Behaviour:
- Reset (reset=0, asynchronous, no clock edge needed): FSM=IDLE; bin_out=0; valid=0; fault=0; err_count=0; prev=0. Applies mid-operation too.
- All outputs are registered. state_in present before rising edge k is reflected on outputs immediately after edge k (latency 1 edge).
- legal(x): exactly one bit of x set. step(p,x): x == rotate-left-by-1 of p (bit WIDTH-1 wraps to bit 0). hold(p,x): x == p.
- FSM IDLE: legal -> TRACK, prev<=x, bin_out<=idx(x), valid<=1. Illegal -> stay IDLE; no error counted (counter still settling from reset).
- FSM TRACK: legal and (step or hold) -> stay, prev<=x, bin_out<=idx(x).
  Otherwise (zero bits, >1 bit, or legal but non-adjacent jump) -> FAULT: valid<=0, fault<=1, err_count += 1; bin_out holds its last value.
- FSM FAULT: legal -> TRACK (resync): prev<=x, bin_out<=idx(x), valid<=1, fault<=0. Illegal -> stay; no further increment.
  Events are counted once, not per cycle.
- Wrap-around: 100 -> 001 is a legal step (bin_out 2 -> 0).
- err_count saturates at 2^ERR_W-1 and never wraps.
- clear_err=1 at edge k: err_count<=0. If an error event occurs at the same edge, err_count<=1 (clear first, then count).
  clear_err does not change FSM state, valid or fault.
- Counter held by preset (state constant) is legal hold, not a fault.

Decomposition:
- Shared package onehot_pkg: FSM state enum {IDLE, TRACK, FAULT}; WIDTH default; IDX_W derivation; rotate-left helper constant/function.
- One sub-module, onehot_decode: combinational, input WIDTH bits, outputs legal flag and IDX_W index (index undefined when illegal; gated by FSM).
- FSM, prev register and error counter live in onehot_state_monitor.

Test Plan:
1. reset=0 with state_in=011, no clock -> bin_out=0, valid=0, fault=0, err_count=0. Release reset with state_in=011 for 2 edges -> still IDLE, err_count=0.
2. Release, drive 001,010,100,001 on successive edges -> bin_out 0,1,2,0; valid=1 from the first edge; fault=0; err_count=0.
3. TRACK at 001, drive 100 -> fault=1, valid=0, err_count=1, bin_out stays 0. Drive 100 for 2 more edges -> TRACK, valid=1, bin_out=2, err_count=1.
4. TRACK at 010, drive 000 for 3 edges then 110 -> err_count=1 (single event); drive 010 -> valid=1, bin_out=1.
   Hold 010 for 4 edges -> no fault.
5. ERR_W=4: generate 20 fault/resync events -> err_count=15. clear_err=1 -> 0. clear_err=1 coincident with new fault -> err_count=1.
6. In TRACK at 100, pull reset low between edges -> outputs zero immediately. Release with 001 -> next edge valid=1, bin_out=0.
